// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Multi-cycle Num_1 - Num_2 - Bin, CHUNK bits per clock, with
//            OV/ZF/NF/CF flags. Optional macro SERIAL_SUBTRACTOR_ADD_MODE_EN
//            adds an Op input that selects Num_1 + Num_2 + Bin instead.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Num_1,
  input  logic [WIDTH-1:0] Num_2,
  input  logic             Bin,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  input  logic             Op,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             OV,
  output logic             ZF,
  output logic             NF,
  output logic             CF
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d, ov_q, ov_d, zf_q, zf_d, nf_q, nf_d, cf_q, cf_d;
  logic             add_mode;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] acc_shift;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic op_q, op_d;
  assign add_mode = op_q;
`else
  assign add_mode = 1'b0;
`endif

  // Operands shift right each cycle so the active chunk is always the low slice.
  always_comb begin
    if (add_mode) begin
      chunk_res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, borrow_q};
    end else begin
      chunk_res = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow_q};
    end
  end

  // Result chunks enter at the top of the accumulator and migrate down.
  generate
    if (CHUNK < WIDTH) begin : g_acc_shift
      assign acc_shift = {chunk_res[CHUNK-1:0], acc_q[WIDTH-1:CHUNK]};
    end else begin : g_acc_full
      assign acc_shift = chunk_res[CHUNK-1:0];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ov_d     = ov_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    cf_d     = cf_q;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    op_d     = op_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          a_d      = Num_1;
          b_d      = Num_2;
          acc_d    = '0;
          borrow_d = Bin;
          a_msb_d  = Num_1[WIDTH-1];
          b_msb_d  = Num_2[WIDTH-1];
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
          op_d     = Op;
`endif
        end
      end
      S_RUN: begin
        a_d      = a_q >> CHUNK;
        b_d      = b_q >> CHUNK;
        acc_d    = acc_shift;
        borrow_d = chunk_res[CHUNK];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_DONE;
          diff_d  = acc_shift;
          bout_d  = chunk_res[CHUNK];
          cf_d    = chunk_res[CHUNK];
          zf_d    = (acc_shift == '0);
          nf_d    = acc_shift[WIDTH-1];
          ov_d    = ((a_msb_q == b_msb_q) == add_mode) && (acc_shift[WIDTH-1] != a_msb_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ov_q     <= 1'b0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      cf_q     <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      op_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ov_q     <= ov_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      cf_q     <= cf_d;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      op_q     <= op_d;
`endif
    end
  end

  assign Busy = (state_q == S_RUN);
  assign Done = (state_q == S_DONE);
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign OV   = ov_q;
  assign ZF   = zf_q;
  assign NF   = nf_q;
  assign CF   = cf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Scoreboard bench for serial_subtractor: directed and random
//            requests, reference results from plain wide arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout, ov, zf, nf, cf;
    int               cyc;
  } exp_t;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             Start = 1'b0;
  logic [WIDTH-1:0] Num_1 = '0;
  logic [WIDTH-1:0] Num_2 = '0;
  logic             Bin = 1'b0;
  logic             Op = 1'b0;
  logic             Busy, Done, Bout, OV, ZF, NF, CF;
  logic [WIDTH-1:0] Diff;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   finish_req = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Num_1(Num_1), .Num_2(Num_2), .Bin(Bin),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    .Op(Op),
`endif
    .Busy(Busy), .Done(Done), .Diff(Diff), .Bout(Bout),
    .OV(OV), .ZF(ZF), .NF(NF), .CF(CF)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                 logic bin, logic op, int done_cyc);
    exp_t e;
    logic [WIDTH:0] r;
    if (op) begin
      r      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, bin};
      e.bout = r[WIDTH];
      e.ov   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else begin
      r      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
      e.bout = ({1'b0, a} < ({1'b0, b} + {{WIDTH{1'b0}}, bin}));
      e.ov   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    e.diff = r[WIDTH-1:0];
    e.zf   = (e.diff == '0);
    e.nf   = e.diff[WIDTH-1];
    e.cf   = e.bout;
    e.cyc  = done_cyc;
    return e;
  endfunction

  // One stimulus cycle: drive at the falling edge; a request is accepted at the
  // next rising edge exactly when Busy is low now.
  task automatic drive(logic s, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic bin, logic op);
    @(negedge Clk);
    Start = s;
    Num_1 = a;
    Num_2 = b;
    Bin   = bin;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    Op    = op;
`else
    Op    = 1'b0;
`endif
    if (s && !Busy && !Rst) q.push_back(model(a, b, bin, Op, cyc + 1 + NCHUNK));
  endtask

  task automatic drive_junk(logic s);
    drive(s, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  function automatic logic [WIDTH-1:0] corner();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  logic [WIDTH-1:0] last_diff = '0;
  int               busy_run  = 0;

  always @(negedge Clk) begin
    if (Rst) begin
      check("reset_outputs", 64'({Busy, Done, Diff, Bout, OV, ZF, NF, CF}), 64'd0);
      q.delete();
      last_diff = '0;
      busy_run  = 0;
    end else if (Done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("diff",  64'(Diff), 64'(e.diff));
        check("flags", 64'({Bout, OV, ZF, NF, CF}), 64'({e.bout, e.ov, e.zf, e.nf, e.cf}));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_len", 64'(busy_run), 64'(NCHUNK));
        check("busy_in_done", 64'(Busy), 64'd0);
        last_diff = e.diff;
      end
      busy_run = 0;
    end else begin
      check("diff_hold", 64'(Diff), 64'(last_diff));
    end
    if (Busy && !Rst) busy_run++;
    if (cyc > 20000) begin
      check("watchdog", 64'(cyc), 64'd20000);
      finish_req = 1'b1;
    end
    if (finish_req) begin
      check("queue_drained", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] dir_a [5] = '{32'd5, 32'd3, 32'h8000_0000, 32'd7, 32'h0000_0100};
  logic [WIDTH-1:0] dir_b [5] = '{32'd3, 32'd5, 32'h0000_0001, 32'd6, 32'h0000_0001};
  logic             dir_c [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    // Directed: each issued in the previous request's DONE cycle, with ignored
    // Start pulses and changing operands while busy.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, dir_a[i], dir_b[i], dir_c[i], 1'b0);
      for (int j = 0; j < NCHUNK; j++) drive_junk(1'b1);
    end
    for (int j = 0; j < NCHUNK + 2; j++) drive_junk(1'b0);

    // Abort in the second RUN cycle; the pending result must never appear.
    drive(1'b1, 32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0);
    @(posedge Clk);
    #1 Start = 1'b0;
    @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    for (int j = 0; j < 3; j++) drive_junk(1'b0);

    drive(1'b1, 32'd100, 32'd58, 1'b0, 1'b0);
    for (int j = 0; j < NCHUNK + 2; j++) drive_junk(1'b0);

    // Random traffic with random Start density.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 2) != 0), corner(), corner(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int j = 0; j < NCHUNK + 2; j++) drive_junk(1'b0);

    for (int j = 0; j < 20 && q.size() != 0; j++) @(posedge Clk);
    finish_req = 1'b1;
  end

endmodule
`default_nettype wire
